// File: rtl/pipeline_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: shadow EX/M/WB control pipeline,
// per-stage enables/flushes, operand forwarding and a data-memory req/ready handshake with timeout.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] i_rs1Addr_ID,
  input  logic [REG_ADDR_W-1:0] i_rs2Addr_ID,
  input  logic [REG_ADDR_W-1:0] i_rd_ID,
  input  logic                  i_reg_write_ID,
  input  logic [1:0]            i_result_src_ID,
  input  logic                  i_mem_write_ID,
  input  logic                  i_pc_src_EX,
  input  logic                  i_dmem_ready,
  output logic                  o_en_IF,
  output logic                  o_en_ID,
  output logic                  o_en_EX,
  output logic                  o_en_M,
  output logic                  o_en_WB,
  output logic                  o_flush_ID,
  output logic                  o_flush_EX,
  output logic [1:0]            o_forward_rs1_EX,
  output logic [1:0]            o_forward_rs2_EX,
  output logic                  o_dmem_req,
  output logic                  o_mem_err,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q, m_rd_q, wb_rd_q;
  logic                  ex_reg_write_q, ex_load_q, ex_store_q;
  logic                  m_reg_write_q, m_load_q, m_store_q, wb_reg_write_q;
  logic [0:0]            state_q, state_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic mem_m, timeout, mem_stall, load_use, id_load;
  logic en_if, en_id, en_ex, en_m, en_wb, flush_id, flush_ex;

  // x0 is never forwarded; the younger producer in M beats the older one in WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic m_wr, input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic wb_wr, input logic [REG_ADDR_W-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs == REG_X0) sel = 2'b00;
    else if (m_wr && (m_rd == rs)) sel = 2'b10;
    else if (wb_wr && (wb_rd == rs)) sel = 2'b01;
    else sel = 2'b00;
    return sel;
  endfunction

  // Memory handshake status for the access sitting in M.
  always_comb begin
    mem_m     = m_load_q | m_store_q;
    timeout   = (state_q == ST_WAIT) & (wait_cnt_q == WCNT_MAX) & ~i_dmem_ready;
    mem_stall = mem_m & ~i_dmem_ready & ~timeout;
    id_load   = (i_result_src_ID == 2'b01);
    load_use  = ex_load_q & (ex_rd_q != REG_X0) &
                ((ex_rd_q == i_rs1Addr_ID) | (ex_rd_q == i_rs2Addr_ID));
  end

  // Prioritised hazard resolution: a branch waiting behind a memory stall is held, not lost.
  always_comb begin
    en_if    = 1'b1;
    en_id    = 1'b1;
    en_ex    = 1'b1;
    en_m     = 1'b1;
    en_wb    = 1'b1;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (mem_stall) begin
      en_if = 1'b0;
      en_id = 1'b0;
      en_ex = 1'b0;
      en_m  = 1'b0;
      en_wb = 1'b0;
    end else if (i_pc_src_EX) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      en_if    = 1'b0;
      en_id    = 1'b0;
      flush_ex = 1'b1;
    end else begin
      flush_id = 1'b0;
    end
  end

  // IDLE/WAIT next state; wait_cnt counts stalled cycles already spent in WAIT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q | timeout;
    case (state_q)
      ST_IDLE: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = {WCNT_W{1'b0}};
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = {WCNT_W{1'b0}};
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = {WCNT_W{1'b0}};
      end
    endcase
  end

  // Saturating count of cycles with any stage held.
  always_comb begin
    if (~(en_if & en_id & en_ex & en_m & en_wb) & ~(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Handshake state, sticky error and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= {WCNT_W{1'b0}};
      err_q       <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Shadow control pipeline; a flushed ID->EX transfer inserts an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rd_q        <= REG_X0;
      ex_rs1_q       <= REG_X0;
      ex_rs2_q       <= REG_X0;
      ex_reg_write_q <= 1'b0;
      ex_load_q      <= 1'b0;
      ex_store_q     <= 1'b0;
      m_rd_q         <= REG_X0;
      m_reg_write_q  <= 1'b0;
      m_load_q       <= 1'b0;
      m_store_q      <= 1'b0;
      wb_rd_q        <= REG_X0;
      wb_reg_write_q <= 1'b0;
    end else begin
      if (en_ex) begin
        ex_rd_q        <= flush_ex ? REG_X0 : i_rd_ID;
        ex_rs1_q       <= flush_ex ? REG_X0 : i_rs1Addr_ID;
        ex_rs2_q       <= flush_ex ? REG_X0 : i_rs2Addr_ID;
        ex_reg_write_q <= ~flush_ex & i_reg_write_ID;
        ex_load_q      <= ~flush_ex & id_load;
        ex_store_q     <= ~flush_ex & i_mem_write_ID;
      end
      if (en_m) begin
        m_rd_q        <= ex_rd_q;
        m_reg_write_q <= ex_reg_write_q;
        m_load_q      <= ex_load_q;
        m_store_q     <= ex_store_q;
      end
      if (en_wb) begin
        wb_rd_q        <= m_rd_q;
        wb_reg_write_q <= m_reg_write_q;
      end
    end
  end

  assign o_en_IF          = en_if;
  assign o_en_ID          = en_id;
  assign o_en_EX          = en_ex;
  assign o_en_M           = en_m;
  assign o_en_WB          = en_wb;
  assign o_flush_ID       = flush_id;
  assign o_flush_EX       = flush_ex;
  assign o_forward_rs1_EX = fwd_sel(ex_rs1_q, m_reg_write_q, m_rd_q, wb_reg_write_q, wb_rd_q);
  assign o_forward_rs2_EX = fwd_sel(ex_rs2_q, m_reg_write_q, m_rd_q, wb_reg_write_q, wb_rd_q);
  assign o_dmem_req       = mem_m & ~timeout;
  assign o_mem_err        = err_q;
  assign o_stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed table, multi-cycle corner sequences
// and randomized traffic against a stage-array reference model.
module tb_pipeline_ctrl;
  localparam int MEM_T   = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = 31;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
    logic       st;
  } ins_t;

  typedef struct packed {
    ins_t       id;
    logic       pc;
    logic       rdy;
    logic [4:0] en;
    logic       fid;
    logic       fex;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       req;
    logic [4:0] cnt;
  } vec_t;

  logic clk, rst;
  logic [3:0] rs1_id, rs2_id, rd_id;
  logic wr_id, mw_id, pc_src, rdy;
  logic [1:0] rsrc_id;
  logic en_IF, en_ID, en_EX, en_M, en_WB, fl_ID, fl_EX, req, err;
  logic [1:0] f1, f2;
  logic [CNT_W-1:0] cnt;
  logic [4:0] dut_en;

  int n_chk = 0;
  int n_fail = 0;

  pipeline_ctrl #(.REG_ADDR_W(4), .MEM_TIMEOUT(MEM_T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_rs1Addr_ID(rs1_id), .i_rs2Addr_ID(rs2_id), .i_rd_ID(rd_id),
    .i_reg_write_ID(wr_id), .i_result_src_ID(rsrc_id), .i_mem_write_ID(mw_id),
    .i_pc_src_EX(pc_src), .i_dmem_ready(rdy),
    .o_en_IF(en_IF), .o_en_ID(en_ID), .o_en_EX(en_EX), .o_en_M(en_M), .o_en_WB(en_WB),
    .o_flush_ID(fl_ID), .o_flush_EX(fl_EX),
    .o_forward_rs1_EX(f1), .o_forward_rs2_EX(f2),
    .o_dmem_req(req), .o_mem_err(err), .o_stall_cnt(cnt)
  );

  assign dut_en = {en_IF, en_ID, en_EX, en_M, en_WB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: instructions in EX/M/WB and the number of cycles the M access has waited.
  ins_t mdl_ex, mdl_m, mdl_wb;
  int   mdl_waited;
  logic mdl_err;
  int   mdl_cnt;
  logic [4:0] x_en;
  logic x_fid, x_fex, x_req, x_timeout, x_mstall;
  logic [1:0] x_f1, x_f2;

  function automatic ins_t mk(input int s1, input int s2, input int d,
                              input bit w, input bit l, input bit s);
    ins_t r;
    r.rs1 = 4'(s1); r.rs2 = 4'(s2); r.rd = 4'(d);
    r.wr = w; r.ld = l; r.st = s;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    r.rs1 = 4'($urandom_range(0, 3));
    r.rs2 = 4'($urandom_range(0, 3));
    r.rd  = 4'($urandom_range(0, 3));
    r.wr  = 1'($urandom_range(0, 1));
    r.ld  = ($urandom_range(0, 3) == 0);
    r.st  = !r.ld && ($urandom_range(0, 5) == 0);
    return r;
  endfunction

  function automatic logic [1:0] mdl_fwd(input logic [3:0] rs);
    if (rs == 4'd0) return 2'b00;
    if (mdl_m.wr && mdl_m.rd == rs) return 2'b10;
    if (mdl_wb.wr && mdl_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic mdl_reset();
    mdl_ex = '0; mdl_m = '0; mdl_wb = '0;
    mdl_waited = 0; mdl_err = 1'b0; mdl_cnt = 0;
  endtask

  task automatic mdl_eval(input ins_t id, input logic pc, input logic r);
    logic mem, luse;
    mem = mdl_m.ld | mdl_m.st;
    x_timeout = mem && !r && (mdl_waited >= MEM_T);
    x_mstall  = mem && !r && !x_timeout;
    luse = mdl_ex.ld && (mdl_ex.rd != 4'd0) && (mdl_ex.rd == id.rs1 || mdl_ex.rd == id.rs2);
    x_en = 5'b11111; x_fid = 1'b0; x_fex = 1'b0;
    if (x_mstall) x_en = 5'b00000;
    else if (pc) begin x_fid = 1'b1; x_fex = 1'b1; end
    else if (luse) begin x_en = 5'b00111; x_fex = 1'b1; end
    x_f1  = mdl_fwd(mdl_ex.rs1);
    x_f2  = mdl_fwd(mdl_ex.rs2);
    x_req = mem && !x_timeout;
  endtask

  task automatic mdl_step(input ins_t id);
    if (x_en != 5'b11111 && mdl_cnt < CNT_MAX) mdl_cnt++;
    if (x_timeout) mdl_err = 1'b1;
    mdl_waited = x_mstall ? mdl_waited + 1 : 0;
    if (x_en[0]) mdl_wb = mdl_m;
    if (x_en[1]) mdl_m = mdl_ex;
    if (x_en[2]) mdl_ex = x_fex ? ins_t'(0) : id;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input ins_t id, input logic pc, input logic r);
    rs1_id = id.rs1; rs2_id = id.rs2; rd_id = id.rd;
    wr_id = id.wr; mw_id = id.st;
    rsrc_id = id.ld ? 2'b01 : (id.wr ? 2'b10 : 2'b00);
    pc_src = pc; rdy = r;
  endtask

  task automatic tick(input ins_t id, input logic pc, input logic r);
    @(negedge clk);
    drive(id, pc, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive('0, 1'b0, 1'b1);
    #1;
    chk("rst_en", dut_en, 5'b11111);
    chk("rst_flush", {fl_ID, fl_EX}, 2'b00);
    chk("rst_fwd", {f1, f2}, 4'b0000);
    chk("rst_req_err", {req, err}, 2'b00);
    chk("rst_cnt", cnt, 5'd0);
    #1 rst = 1'b1;
    mdl_reset();
  endtask

  vec_t vecs[12];
  ins_t lw, cur;
  int reqs;

  initial begin
    rst = 1'b0;
    drive('0, 1'b0, 1'b1);

    // add x3 / sub x4,x3,x3, bubble-apart forwarding, x0, M-over-WB, lw/add load-use
    vecs[0]  = '{mk(1,2,3,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[1]  = '{mk(3,3,4,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[2]  = '{mk(0,0,0,0,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 5'd0};
    vecs[3]  = '{mk(4,4,6,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[4]  = '{mk(0,0,0,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 5'd0};
    vecs[5]  = '{mk(0,6,7,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[6]  = '{mk(1,1,7,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 5'd0};
    vecs[7]  = '{mk(7,7,9,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[8]  = '{mk(1,0,5,1,1,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 5'd0};
    vecs[9]  = '{mk(5,1,6,1,0,0), 1'b0, 1'b1, 5'b00111, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0};
    vecs[10] = '{mk(5,1,6,1,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd1};
    vecs[11] = '{mk(0,0,0,0,0,0), 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 5'd1};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].id, vecs[i].pc, vecs[i].rdy);
      chk($sformatf("vec%0d_en", i), dut_en, vecs[i].en);
      chk($sformatf("vec%0d_flush", i), {fl_ID, fl_EX}, {vecs[i].fid, vecs[i].fex});
      chk($sformatf("vec%0d_fwd1", i), f1, vecs[i].f1);
      chk($sformatf("vec%0d_fwd2", i), f2, vecs[i].f2);
      chk($sformatf("vec%0d_req", i), req, vecs[i].req);
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].cnt);
    end

    // Load with ready low for 3 cycles
    lw = mk(1,0,2,1,1,0);
    do_reset();
    tick(lw, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    reqs = 0;
    for (int k = 0; k < 5; k++) begin
      tick('0, 1'b0, k >= 3);
      if (req) reqs++;
      if (k < 3) chk($sformatf("wait3_en%0d", k), dut_en, 5'b00000);
      else if (k == 3) chk("wait3_release_en", dut_en, 5'b11111);
      else chk("wait3_cnt", cnt, 5'd3);
    end
    chk("wait3_req_cycles", reqs, 4);

    // Taken branch in EX while M waits 2 cycles
    do_reset();
    tick(mk(1,2,0,0,0,1), 1'b0, 1'b0);
    tick(mk(3,4,0,0,0,0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick('0, 1'b1, k == 2);
      if (k < 2) begin
        chk($sformatf("br_wait_flush%0d", k), {fl_ID, fl_EX}, 2'b00);
        chk($sformatf("br_wait_en%0d", k), dut_en, 5'b00000);
      end else begin
        chk("br_rel_flush", {fl_ID, fl_EX}, 2'b11);
        chk("br_rel_en", dut_en, 5'b11111);
        chk("br_rel_req", req, 1'b1);
      end
    end
    tick('0, 1'b0, 1'b1);
    chk("br_cnt", cnt, 5'd2);

    // Timeout: ready never comes
    do_reset();
    tick(lw, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick('0, 1'b0, 1'b0);
      if (k < 4) chk($sformatf("to_stall%0d", k), {dut_en, req, err}, {5'b00000, 1'b1, 1'b0});
      else if (k == 4) chk("to_release", {dut_en, req, err}, {5'b11111, 1'b0, 1'b0});
      else chk("to_after", {dut_en, req, err}, {5'b11111, 1'b0, 1'b1});
    end
    chk("to_cnt", cnt, 5'd4);
    tick(lw, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    chk("to_next_access", {dut_en, req, err}, {5'b11111, 1'b1, 1'b1});

    // Back-to-back timeouts drive the counter into saturation
    for (int k = 0; k < 60; k++) tick(lw, 1'b0, 1'b0);
    chk("sat_cnt", cnt, 5'd31);
    chk("sat_err", err, 1'b1);

    // Asynchronous reset while waiting
    do_reset();
    tick(lw, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick('0, 1'b0, 1'b0);
    chk("arst_pre", {dut_en, req}, {5'b00000, 1'b1});
    #1 rst = 1'b0;
    #1;
    chk("arst_req", req, 1'b0);
    chk("arst_en", dut_en, 5'b11111);
    chk("arst_cnt", cnt, 5'd0);
    rst = 1'b1;
    drive('0, 1'b0, 1'b1);

    // Randomized traffic against the model
    do_reset();
    cur = '0;
    for (int i = 0; i < 2000; i++) begin
      logic pc, r;
      if (i % 250 == 249) begin
        do_reset();
        cur = '0;
      end
      pc = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      drive(cur, pc, r);
      #1;
      mdl_eval(cur, pc, r);
      chk($sformatf("rnd%0d_en", i), dut_en, x_en);
      chk($sformatf("rnd%0d_flush", i), {fl_ID, fl_EX}, {x_fid, x_fex});
      chk($sformatf("rnd%0d_fwd1", i), f1, x_f1);
      chk($sformatf("rnd%0d_fwd2", i), f2, x_f2);
      chk($sformatf("rnd%0d_req", i), req, x_req);
      chk($sformatf("rnd%0d_err", i), err, mdl_err);
      chk($sformatf("rnd%0d_cnt", i), cnt, mdl_cnt);
      @(posedge clk);
      mdl_step(cur);
      if (x_en[3]) cur = x_fid ? ins_t'(0) : rand_ins();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
